// File: rtl/monolith_axis_pkg.sv
// Shared types and default geometry for the Monolith AXI4-Stream slave/master
// chunk interfaces.
package monolith_axis_pkg;

  localparam int CHUNK_SIZE_DEFAULT  = 16;
  localparam int CHUNK_COUNT_DEFAULT = 2;
  localparam int TDATA_WIDTH_DEFAULT = 32;

  // Sized for the shared default chunk size (words ranges 1..SIZE).
  typedef struct packed {
    logic                                  last;
    logic [$clog2(CHUNK_SIZE_DEFAULT):0]   words;
  } chunk_meta_t;

endpackage

// File: rtl/monolith_chunk_ram.sv
// COUNT x SIZE word register array: single-word write port, whole-chunk
// combinational read port.
module monolith_chunk_ram
  import monolith_axis_pkg::*;
#(
  parameter int SIZE  = CHUNK_SIZE_DEFAULT,
  parameter int COUNT = CHUNK_COUNT_DEFAULT,
  parameter int WIDTH = TDATA_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(COUNT)-1:0] wr_chunk,
  input  logic [$clog2(SIZE)-1:0]  wr_word,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(COUNT)-1:0] rd_chunk,
  output logic [WIDTH-1:0]         rd_data [0:SIZE-1]
);

  logic [WIDTH-1:0] mem [0:COUNT-1][0:SIZE-1];

  // NOTE: storage has no reset; stale contents are hidden by the word-count
  // masking in the top level, so clearing it would only cost reset fanout.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_chunk][wr_word] <= wr_data;
  end

  always_comb begin
    for (int i = 0; i < SIZE; i++) rd_data[i] = mem[rd_chunk][i];
  end

endmodule

// File: rtl/monolith_axis_ip_slave_sif.sv
// AXI4-Stream slave: packs serial words into chunks, buffers COUNT chunks and
// presents the head chunk in parallel to the core, which pops it with a strobe.
module monolith_axis_ip_slave_sif
  import monolith_axis_pkg::*;
#(
  parameter int FIFO_CHUNK_SIZE      = CHUNK_SIZE_DEFAULT,
  parameter int FIFO_CHUNK_COUNT     = CHUNK_COUNT_DEFAULT,
  parameter int C_S_AXIS_TDATA_WIDTH = TDATA_WIDTH_DEFAULT
) (
  input  logic                              S_AXIS_ACLK,
  input  logic                              S_AXIS_ARESET,
  input  logic                              S_AXIS_TVALID,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic                              S_AXIS_TLAST,
  output logic                              S_AXIS_TREADY,
  input  logic                              fifo_read_strobe,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0]   fifo_out [0:FIFO_CHUNK_SIZE-1],
  output logic [$clog2(FIFO_CHUNK_SIZE):0]  fifo_out_words,
  output logic                              fifo_out_last,
  output logic                              fifo_empty
);

  localparam int CHUNK_AW = $clog2(FIFO_CHUNK_COUNT);
  localparam int WORD_AW  = $clog2(FIFO_CHUNK_SIZE);
  localparam int LEVEL_W  = CHUNK_AW + 1;

  typedef logic [WORD_AW:0] word_cnt_t;

  logic [WORD_AW-1:0]  wr_word;
  logic [CHUNK_AW-1:0] wr_chunk;
  logic [CHUNK_AW-1:0] rd_chunk;
  logic [LEVEL_W-1:0]  level;
  chunk_meta_t         meta [0:FIFO_CHUNK_COUNT-1];

  logic                            accept;
  logic                            commit;
  logic                            pop;
  logic                            level_empty;
  word_cnt_t                       commit_words;
  chunk_meta_t                     head_meta;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] raw_chunk [0:FIFO_CHUNK_SIZE-1];

  // TSTRB is ignored: only full words are carried.
  logic unused_tstrb;
  assign unused_tstrb = ^S_AXIS_TSTRB;

  assign level_empty   = (level == '0);
  assign S_AXIS_TREADY = (level != LEVEL_W'(FIFO_CHUNK_COUNT)) & ~S_AXIS_ARESET;
  assign fifo_empty    = level_empty | S_AXIS_ARESET;

  assign accept       = S_AXIS_TVALID & S_AXIS_TREADY;
  assign commit       = accept & ((wr_word == WORD_AW'(FIFO_CHUNK_SIZE - 1)) | S_AXIS_TLAST);
  assign pop          = fifo_read_strobe & ~fifo_empty;
  assign commit_words = {1'b0, wr_word} + word_cnt_t'(1);

  monolith_chunk_ram #(
    .SIZE  (FIFO_CHUNK_SIZE),
    .COUNT (FIFO_CHUNK_COUNT),
    .WIDTH (C_S_AXIS_TDATA_WIDTH)
  ) u_chunk_ram (
    .clk      (S_AXIS_ACLK),
    .wr_en    (accept),
    .wr_chunk (wr_chunk),
    .wr_word  (wr_word),
    .wr_data  (S_AXIS_TDATA),
    .rd_chunk (rd_chunk),
    .rd_data  (raw_chunk)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      wr_word  <= '0;
      wr_chunk <= '0;
      rd_chunk <= '0;
      level    <= '0;
      for (int c = 0; c < FIFO_CHUNK_COUNT; c++) meta[c] <= '0;
    end else begin
      if (accept) begin
        if (commit) begin
          meta[wr_chunk] <= '{last: S_AXIS_TLAST, words: commit_words};
          wr_chunk       <= wr_chunk + CHUNK_AW'(1);
          wr_word        <= '0;
        end else begin
          wr_word <= wr_word + WORD_AW'(1);
        end
      end
      if (pop) rd_chunk <= rd_chunk + CHUNK_AW'(1);
      case ({commit, pop})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // infer a latch.
  always_comb begin
    head_meta      = meta[rd_chunk];
    fifo_out_words = '0;
    fifo_out_last  = 1'b0;
    if (!fifo_empty) begin
      fifo_out_words = head_meta.words;
      fifo_out_last  = head_meta.last;
    end
    // Words past the chunk's fill count read as zero (short-packet padding).
    for (int i = 0; i < FIFO_CHUNK_SIZE; i++) begin
      fifo_out[i] = '0;
      if (word_cnt_t'(i) < fifo_out_words) fifo_out[i] = raw_chunk[i];
    end
  end

endmodule

// File: tb/tb_monolith_axis_ip_slave_sif.sv
// Directed bench for monolith_axis_ip_slave_sif (SIZE=16, COUNT=2, 32-bit).
module tb_monolith_axis_ip_slave_sif;

  logic        clk = 1'b0;
  logic        rst;
  logic        tvalid;
  logic [31:0] tdata;
  logic [3:0]  tstrb;
  logic        tlast;
  logic        tready;
  logic        strobe;
  logic [31:0] fifo_out [0:15];
  logic [4:0]  out_words;
  logic        out_last;
  logic        empty;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  monolith_axis_ip_slave_sif dut (
    .S_AXIS_ACLK      (clk),
    .S_AXIS_ARESET    (rst),
    .S_AXIS_TVALID    (tvalid),
    .S_AXIS_TDATA     (tdata),
    .S_AXIS_TSTRB     (tstrb),
    .S_AXIS_TLAST     (tlast),
    .S_AXIS_TREADY    (tready),
    .fifo_read_strobe (strobe),
    .fifo_out         (fifo_out),
    .fifo_out_words   (out_words),
    .fifo_out_last    (out_last),
    .fifo_empty       (empty)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input logic [31:0] d, input logic last);
    int guard = 0;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = last;
    while (!tready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("push_timeout", 32'(tready), 32'd1);
    @(negedge clk);
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic pop();
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; tvalid = 1'b0; tdata = '0; tstrb = 4'hF; tlast = 1'b0; strobe = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tready", 32'(tready), 32'd0);
    check("rst_empty",  32'(empty),  32'd1);
    check("rst_words",  32'(out_words), 32'd0);
    check("rst_last",   32'(out_last),  32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_tready", 32'(tready), 32'd1);

    // 1: full 16-word packet
    for (int i = 0; i < 15; i++) push(32'h100 + i, 1'b0);
    check("t1_empty_before_last", 32'(empty), 32'd1);
    push(32'h10F, 1'b1);
    check("t1_empty",  32'(empty), 32'd0);
    check("t1_out0",   fifo_out[0],  32'h100);
    check("t1_out15",  fifo_out[15], 32'h10F);
    check("t1_words",  32'(out_words), 32'd16);
    check("t1_last",   32'(out_last),  32'd1);
    pop();
    check("t1_empty_after_pop", 32'(empty), 32'd1);

    // 2: backpressure with strobe low
    for (int i = 0; i < 32; i++) push(32'h200 + i, 1'b0);
    check("t2_tready_full", 32'(tready), 32'd0);
    check("t2_last_open",   32'(out_last), 32'd0);
    tvalid = 1'b1; tdata = 32'h220; tlast = 1'b0;
    repeat (2) @(negedge clk);
    check("t2_stall_tready", 32'(tready), 32'd0);
    check("t2_head_held",    fifo_out[0], 32'h200);
    strobe = 1'b1;
    @(negedge clk);
    strobe = 1'b0;
    check("t2_tready_after_pop", 32'(tready), 32'd1);
    check("t2_head_next",        fifo_out[0], 32'h210);
    @(negedge clk);
    tvalid = 1'b0;
    for (int i = 1; i < 8; i++) push(32'h220 + i, (i == 7));
    check("t2_words_mid", 32'(out_words), 32'd16);
    pop();
    check("t2_out0_tail",  fifo_out[0], 32'h220);
    check("t2_out7_tail",  fifo_out[7], 32'h227);
    check("t2_out8_pad",   fifo_out[8], 32'h0);
    check("t2_words_tail", 32'(out_words), 32'd8);
    check("t2_last_tail",  32'(out_last), 32'd1);
    pop();
    check("t2_empty_end", 32'(empty), 32'd1);

    // 3: short packet, zero padding, next packet starts at word 0
    for (int i = 0; i < 5; i++) push(32'hA0 + i, (i == 4));
    check("t3_words", 32'(out_words), 32'd5);
    check("t3_last",  32'(out_last),  32'd1);
    check("t3_out4",  fifo_out[4], 32'hA4);
    for (int i = 5; i < 16; i++) check($sformatf("t3_pad%0d", i), fifo_out[i], 32'h0);
    for (int i = 0; i < 16; i++) push(32'hB0 + i, (i == 15));
    pop();
    check("t3_next_out0",  fifo_out[0],  32'hB0);
    check("t3_next_out15", fifo_out[15], 32'hBF);
    check("t3_next_words", 32'(out_words), 32'd16);
    pop();

    // 4: commit and pop in the same cycle at level 1
    for (int i = 0; i < 4; i++) push(32'hC0 + i, (i == 3));
    for (int i = 0; i < 3; i++) push(32'hD0 + i, 1'b0);
    tvalid = 1'b1; tdata = 32'hD3; tlast = 1'b1; strobe = 1'b1;
    @(negedge clk);
    tvalid = 1'b0; tlast = 1'b0; strobe = 1'b0;
    check("t4_empty",  32'(empty), 32'd0);
    check("t4_tready", 32'(tready), 32'd1);
    check("t4_out0",   fifo_out[0], 32'hD0);
    check("t4_out3",   fifo_out[3], 32'hD3);
    check("t4_words",  32'(out_words), 32'd4);
    pop();
    check("t4_empty_after", 32'(empty), 32'd1);

    // 5: strobe while empty is ignored
    strobe = 1'b1;
    repeat (2) @(negedge clk);
    strobe = 1'b0;
    check("t5_empty",  32'(empty), 32'd1);
    check("t5_words",  32'(out_words), 32'd0);
    check("t5_tready", 32'(tready), 32'd1);
    push(32'hE0, 1'b1);
    check("t5_out0",  fifo_out[0], 32'hE0);
    check("t5_out1",  fifo_out[1], 32'h0);
    check("t5_words1", 32'(out_words), 32'd1);
    check("t5_last1",  32'(out_last), 32'd1);

    // 6: reset mid-packet discards buffered and partial chunks
    for (int i = 0; i < 7; i++) push(32'hF0 + i, 1'b0);
    rst = 1'b1;
    #1;
    check("t6_rst_tready", 32'(tready), 32'd0);
    check("t6_rst_empty",  32'(empty),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_empty_after", 32'(empty), 32'd1);
    for (int i = 0; i < 16; i++) push(32'h400 + i, (i == 15));
    check("t6_out0",  fifo_out[0], 32'h400);
    check("t6_out6",  fifo_out[6], 32'h406);
    check("t6_words", 32'(out_words), 32'd16);
    check("t6_last",  32'(out_last), 32'd1);
    pop();
    check("t6_empty_end", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
